// File: rtl/double_result_reorder_buffer_if.sv
// Issuer/consumer side of the reorder buffer: tag allocation, tagged result capture
// and the in-order retire stream, grouped for the buffer and its neighbours.
interface double_result_reorder_buffer_if #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 4
);
   logic              alloc_req;
   logic              alloc_grant;
   logic [TAG_W-1:0]  alloc_tag;
   logic              result_done;
   logic [TAG_W-1:0]  result_tag;
   logic [DATA_W-1:0] result_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_tag;
   logic [TAG_W:0]    count;
   logic              err;

   modport master (
      output alloc_req, result_done, result_tag, result_data, out_ready,
      input  alloc_grant, alloc_tag, out_valid, out_data, out_tag, count, err
   );

   modport slave (
      input  alloc_req, result_done, result_tag, result_data, out_ready,
      output alloc_grant, alloc_tag, out_valid, out_data, out_tag, count, err
   );
endinterface

// File: rtl/double_result_reorder_buffer.sv
// Tag allocator plus per-tag result slots; results leave strictly in allocation
// order regardless of the order in which tagged results come back.
module double_result_reorder_buffer #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   double_result_reorder_buffer_if.slave rob
);
   localparam int             DEPTH   = 2 ** TAG_W;
   localparam logic [TAG_W:0] DEPTH_C = (TAG_W + 1)'(DEPTH);

   logic [DEPTH-1:0]  r_pending;
   logic [DEPTH-1:0]  r_filled;
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [TAG_W-1:0]  r_alloc_ptr;
   logic [TAG_W-1:0]  r_head_ptr;
   logic [TAG_W:0]    r_count;
   logic              r_err;

   logic w_grant;
   logic w_capture;
   logic w_valid;
   logic w_retire;

   // Full blocks allocation even when the head retires this cycle: no bypass path.
   assign w_grant   = rob.alloc_req & ~reset & (r_count < DEPTH_C);
   assign w_capture = rob.result_done & r_pending[rob.result_tag] & ~r_filled[rob.result_tag];
   assign w_valid   = r_pending[r_head_ptr] & r_filled[r_head_ptr];
   assign w_retire  = w_valid & rob.out_ready;

   assign rob.alloc_grant = w_grant;
   assign rob.alloc_tag   = r_alloc_ptr;
   assign rob.out_valid   = w_valid;
   assign rob.out_data    = r_data[r_head_ptr];
   assign rob.out_tag     = r_head_ptr;
   assign rob.count       = r_count;
   assign rob.err         = r_err;

   // Grant, capture and retire always address distinct slots: the grant slot is
   // not pending, capture needs an unfilled pending slot, retire needs a filled one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
         r_filled  <= '0;
      end else begin
         if (w_grant) begin
            r_pending[r_alloc_ptr] <= 1'b1;
            r_filled[r_alloc_ptr]  <= 1'b0;
         end
         if (w_retire) begin
            r_pending[r_head_ptr] <= 1'b0;
            r_filled[r_head_ptr]  <= 1'b0;
         end
         if (w_capture)
            r_filled[rob.result_tag] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture)
         r_data[rob.result_tag] <= rob.result_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alloc_ptr <= '0;
         r_head_ptr  <= '0;
         r_count     <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_grant)
            r_alloc_ptr <= r_alloc_ptr + 1'b1;
         if (w_retire)
            r_head_ptr <= r_head_ptr + 1'b1;
         case ({w_grant, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (rob.result_done & ~w_capture)
            r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_double_result_reorder_buffer.sv
// Directed and randomized checks of tag allocation, out-of-order capture and in-order retire.
module tb_double_result_reorder_buffer;
   localparam int DATA_W = 64;
   localparam int TAG_W  = 4;

   localparam logic [63:0] D1 = 64'h3FF0_0000_0000_0000;  // 1.0
   localparam logic [63:0] D2 = 64'h4000_0000_0000_0000;  // 2.0
   localparam logic [63:0] D3 = 64'h4008_0000_0000_0000;  // 3.0
   localparam logic [63:0] DA = 64'h4010_0000_0000_0000;  // 4.0
   localparam logic [63:0] DB = 64'h4014_0000_0000_0000;  // 5.0

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   double_result_reorder_buffer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   double_result_reorder_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .rob   (bus)
   );

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [63:0]      d;
   } ent_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alloc_req   = 1'b0;
      bus.result_done = 1'b0;
      bus.result_tag  = '0;
      bus.result_data = '0;
      bus.out_ready   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic put_result(input logic [TAG_W-1:0] t, input logic [63:0] d);
      bus.result_done = 1'b1;
      bus.result_tag  = t;
      bus.result_data = d;
   endtask

   logic [63:0]      tdat [16];
   ent_t             expq [$];
   int               pool [$];
   int               mcount;
   int               retired;
   int               idx;
   logic [TAG_W-1:0] mptr;
   logic [TAG_W-1:0] t;
   bit               areq;

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) step();
      chk("rst_count", bus.count, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_alloc_tag", bus.alloc_tag, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      bus.alloc_req = 1'b1;
      #1;
      chk("rst_grant_blocked", bus.alloc_grant, 0);

      // allocate tags 0,1,2 back to back
      reset = 1'b0;
      #1;
      chk("t1_grant0", bus.alloc_grant, 1);
      chk("t1_tag0", bus.alloc_tag, 0);
      step();
      chk("t1_tag1", bus.alloc_tag, 1);
      step();
      chk("t1_tag2", bus.alloc_tag, 2);
      step();
      bus.alloc_req = 1'b0;
      #1;
      chk("t1_count", bus.count, 3);
      chk("t1_out_valid", bus.out_valid, 0);

      // results 2,0,1 out of order; retire in order 0,1,2
      put_result(2, D3);
      step();
      put_result(0, D1);
      #1;
      chk("t2_not_head", bus.out_valid, 0);
      step();
      chk("t2_v0", bus.out_valid, 1);
      chk("t2_tag0", bus.out_tag, 0);
      chk("t2_data0", bus.out_data, D1);
      put_result(1, D2);
      bus.out_ready = 1'b1;
      step();
      bus.result_done = 1'b0;
      #1;
      chk("t2_tag1", bus.out_tag, 1);
      chk("t2_data1", bus.out_data, D2);
      chk("t2_count2", bus.count, 2);
      step();
      chk("t2_tag2", bus.out_tag, 2);
      chk("t2_data2", bus.out_data, D3);
      step();
      chk("t2_empty", bus.out_valid, 0);
      chk("t2_count0", bus.count, 0);
      chk("t2_err", bus.err, 0);
      bus.out_ready = 1'b0;

      // fill to 16, no bypass when full, wrap to tag 0
      do_reset();
      bus.alloc_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t3_tag%0d", i), bus.alloc_tag, 64'(i));
         step();
      end
      chk("t3_full_count", bus.count, 16);
      chk("t3_full_nogrant", bus.alloc_grant, 0);
      put_result(0, D1);
      step();
      bus.result_done = 1'b0;
      bus.out_ready   = 1'b1;
      #1;
      chk("t3_head_valid", bus.out_valid, 1);
      chk("t3_nobypass", bus.alloc_grant, 0);
      step();
      chk("t3_count15", bus.count, 15);
      chk("t3_wrap_grant", bus.alloc_grant, 1);
      chk("t3_wrap_tag", bus.alloc_tag, 0);
      bus.out_ready = 1'b0;
      step();
      bus.alloc_req = 1'b0;
      #1;
      chk("t3_refull", bus.count, 16);

      // head held while consumer stalls; alloc+retire same cycle
      put_result(1, D2);
      step();
      bus.result_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold_valid", bus.out_valid, 1);
         chk("t4_hold_data", bus.out_data, D2);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      put_result(2, D3);
      step();
      bus.result_done = 1'b0;
      bus.alloc_req   = 1'b1;
      bus.out_ready   = 1'b1;
      #1;
      chk("t4_grant", bus.alloc_grant, 1);
      chk("t4_grant_tag", bus.alloc_tag, 1);
      chk("t4_head_tag", bus.out_tag, 2);
      step();
      bus.alloc_req = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("t4_count_same", bus.count, 15);

      // result in the same cycle as its grant is an error
      do_reset();
      bus.alloc_req = 1'b1;
      put_result(0, DA);
      #1;
      chk("t5_same_grant", bus.alloc_grant, 1);
      step();
      bus.alloc_req   = 1'b0;
      bus.result_done = 1'b0;
      #1;
      chk("t5_same_err", bus.err, 1);
      chk("t5_same_dropped", bus.out_valid, 0);
      chk("t5_same_count", bus.count, 1);

      // result for an unallocated tag
      do_reset();
      bus.alloc_req = 1'b1;
      repeat (2) step();
      bus.alloc_req = 1'b0;
      put_result(7, DA);
      step();
      bus.result_done = 1'b0;
      #1;
      chk("t5_unalloc_err", bus.err, 1);
      chk("t5_unalloc_count", bus.count, 2);
      chk("t5_unalloc_valid", bus.out_valid, 0);

      // duplicate result for a filled tag
      do_reset();
      bus.alloc_req = 1'b1;
      repeat (2) step();
      bus.alloc_req = 1'b0;
      put_result(0, DA);
      step();
      bus.result_done = 1'b0;
      #1;
      chk("t5_ok_err", bus.err, 0);
      chk("t5_ok_data", bus.out_data, DA);
      put_result(0, DB);
      step();
      bus.result_done = 1'b0;
      #1;
      chk("t5_dup_err", bus.err, 1);
      chk("t5_dup_data", bus.out_data, DA);
      repeat (5) step();
      chk("t5_sticky", bus.err, 1);

      // reset with entries outstanding
      bus.alloc_req = 1'b1;
      repeat (3) step();
      bus.alloc_req = 1'b0;
      #1;
      chk("t6_pre_count", bus.count, 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("t6_count", bus.count, 0);
      chk("t6_valid", bus.out_valid, 0);
      chk("t6_err", bus.err, 0);
      chk("t6_tag", bus.alloc_tag, 0);
      bus.alloc_req = 1'b1;
      #1;
      chk("t6_grant", bus.alloc_grant, 1);
      bus.alloc_req = 1'b0;

      // random traffic with out-of-order completion against a queue model
      do_reset();
      mcount  = 0;
      retired = 0;
      mptr    = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         areq          = (cyc < 3000) && ($urandom_range(0, 3) != 0);
         bus.alloc_req = areq;
         bus.out_ready = (cyc >= 3000) || ($urandom_range(0, 2) != 0);
         if (pool.size() > 0 && ((cyc >= 3000) || $urandom_range(0, 1) == 1)) begin
            idx = $urandom_range(0, pool.size() - 1);
            t   = TAG_W'(pool[idx]);
            put_result(t, tdat[t]);
            pool.delete(idx);
         end else begin
            bus.result_done = 1'b0;
         end
         #1;
         chk("t7_grant", bus.alloc_grant, 64'(areq && (mcount < 16)));
         if (bus.alloc_grant) begin
            t = bus.alloc_tag;
            chk("t7_alloc_tag", t, mptr);
            tdat[t] = {$urandom, $urandom};
            pool.push_back(int'(t));
            expq.push_back('{tag: t, d: tdat[t]});
            mptr++;
            mcount++;
         end
         if (expq.size() == 0)
            chk("t7_empty_valid", bus.out_valid, 0);
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               chk("t7_retire_unexpected", 1, 0);
            end else begin
               chk("t7_out_tag", bus.out_tag, expq[0].tag);
               chk("t7_out_data", bus.out_data, expq[0].d);
               void'(expq.pop_front());
               mcount--;
               retired++;
            end
         end
         step();
         chk("t7_count", bus.count, 64'(mcount));
      end
      idle_inputs();
      chk("t7_drained", 64'(expq.size()), 0);
      chk("t7_retired_enough", 64'(retired >= 1000), 1);
      chk("t7_err", bus.err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
